// File: rtl/sdr_app_traffic_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sdr_app_traffic_gen_if : SDRAM controller application-port bus             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface sdr_app_traffic_gen_if #(
    parameter int APP_DW = 32,
    parameter int APP_BW = 4,
    parameter int AW     = 26,
    parameter int LW     = 9
);
    logic              app_req;
    logic [AW-1:0]     app_req_addr;
    logic [LW-1:0]     app_req_len;
    logic              app_req_wr_n;
    logic              app_req_wrap;
    logic [APP_DW-1:0] app_wr_data;
    logic [APP_BW-1:0] app_wr_en_n;
    logic              app_req_ack;
    logic              app_wr_next_req;
    logic [APP_DW-1:0] app_rd_data;
    logic              app_rd_valid;
    logic              app_last_rd;

    modport master (
        output app_req, app_req_addr, app_req_len, app_req_wr_n, app_req_wrap,
               app_wr_data, app_wr_en_n,
        input  app_req_ack, app_wr_next_req, app_rd_data, app_rd_valid, app_last_rd
    );

    modport slave (
        input  app_req, app_req_addr, app_req_len, app_req_wr_n, app_req_wrap,
               app_wr_data, app_wr_en_n,
        output app_req_ack, app_wr_next_req, app_rd_data, app_rd_valid, app_last_rd
    );
endinterface
`default_nettype wire

// File: rtl/sdr_app_traffic_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sdr_app_traffic_gen : pattern write / read-check burst initiator           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module sdr_app_traffic_gen #(
    parameter int APP_DW = 32,
    parameter int APP_BW = 4,
    parameter int AW     = 26,
    parameter int LW     = 9
) (
    input  logic               sdram_clk,
    input  logic               reset_n,
    input  logic               sdr_init_done,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_wr_n,
    input  logic [AW-1:0]      cmd_addr,
    input  logic [LW-1:0]      cmd_len,
    input  logic [APP_DW-1:0]  cmd_seed,
    sdr_app_traffic_gen_if.master app,
    output logic               busy,
    output logic               done,
    output logic [15:0]        err_cnt,
    output logic               proto_err
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WDATA = 3'd2,
        S_RDATA = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            r_state;
    logic              r_req;
    logic [AW-1:0]     r_addr;
    logic [LW-1:0]     r_len;
    logic [LW-1:0]     r_idx;
    logic              r_wr_n;
    logic [APP_DW-1:0] r_seed;
    logic [APP_DW-1:0] r_wr_data;

    logic              w_accept;
    logic              w_wr_beat;
    logic              w_rd_beat;
    logic              w_last_beat;
    logic              w_rd_mismatch;
    logic [LW-1:0]     w_idx_inc;

    assign w_accept      = (r_state == S_IDLE) && cmd_valid && cmd_ready;
    // Data beats are honoured from the request phase onward, ack cycle included.
    assign w_wr_beat     = ((r_state == S_REQ) || (r_state == S_WDATA)) && !r_wr_n && app.app_wr_next_req;
    assign w_rd_beat     = ((r_state == S_REQ) || (r_state == S_RDATA)) && r_wr_n && app.app_rd_valid;
    assign w_last_beat   = (r_idx == (r_len - 1'b1));
    assign w_idx_inc     = r_idx + 1'b1;
    assign w_rd_mismatch = (app.app_rd_data != (r_seed + APP_DW'(r_idx)));

    assign app.app_req      = r_req;
    assign app.app_req_addr = r_addr;
    assign app.app_req_len  = r_len;
    assign app.app_req_wr_n = r_wr_n;
    assign app.app_req_wrap = 1'b0;
    assign app.app_wr_data  = r_wr_data;
    assign app.app_wr_en_n  = {APP_BW{1'b0}};

    always_ff @(posedge sdram_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_req     <= 1'b0;
            r_addr    <= '0;
            r_len     <= '0;
            r_idx     <= '0;
            r_wr_n    <= 1'b0;
            r_seed    <= '0;
            r_wr_data <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_cnt   <= '0;
            proto_err <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    cmd_ready <= sdr_init_done;
                    if (w_accept) begin
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        r_addr    <= cmd_addr;
                        r_len     <= cmd_len;
                        r_wr_n    <= cmd_wr_n;
                        r_seed    <= cmd_seed;
                        r_idx     <= '0;
                        err_cnt   <= '0;
                        if (cmd_len == '0) begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                        end else begin
                            r_state   <= S_REQ;
                            r_req     <= 1'b1;
                            r_wr_data <= cmd_seed;
                        end
                    end
                end
                S_REQ: begin
                    if (app.app_req_ack) begin
                        r_req   <= 1'b0;
                        r_state <= r_wr_n ? S_RDATA : S_WDATA;
                    end
                end
                S_WDATA, S_RDATA: ;
                S_DONE: begin
                    r_state   <= S_IDLE;
                    busy      <= 1'b0;
                    cmd_ready <= sdr_init_done;
                end
                default: r_state <= S_IDLE;
            endcase

            // Beat handling comes last so burst completion overrides the ack transition.
            if (w_wr_beat) begin
                r_idx     <= w_idx_inc;
                r_wr_data <= r_seed + APP_DW'(w_idx_inc);
                if (w_last_beat) begin
                    r_state <= S_DONE;
                    r_req   <= 1'b0;
                    done    <= 1'b1;
                end
            end

            if (w_rd_beat) begin
                r_idx <= w_idx_inc;
                if (w_rd_mismatch && (err_cnt != 16'hFFFF)) begin
                    err_cnt <= err_cnt + 16'd1;
                end
                if (w_last_beat) begin
                    r_state <= S_DONE;
                    r_req   <= 1'b0;
                    done    <= 1'b1;
                end else if (app.app_last_rd) begin
                    proto_err <= 1'b1;
                    r_state   <= S_DONE;
                    r_req     <= 1'b0;
                    done      <= 1'b1;
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_sdr_app_traffic_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sdr_app_traffic_gen : scoreboard bench with a behavioural controller    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_sdr_app_traffic_gen;
    localparam int APP_DW = 32;
    localparam int APP_BW = 4;
    localparam int AW     = 26;
    localparam int LW     = 9;

    logic              sdram_clk     = 1'b0;
    logic              reset_n       = 1'b0;
    logic              sdr_init_done = 1'b0;
    logic              cmd_valid     = 1'b0;
    logic              cmd_wr_n      = 1'b0;
    logic [AW-1:0]     cmd_addr      = '0;
    logic [LW-1:0]     cmd_len       = '0;
    logic [APP_DW-1:0] cmd_seed      = '0;
    logic              cmd_ready;
    logic              busy;
    logic              done;
    logic [15:0]       err_cnt;
    logic              proto_err;

    sdr_app_traffic_gen_if #(.APP_DW(APP_DW), .APP_BW(APP_BW), .AW(AW), .LW(LW)) app_if ();

    sdr_app_traffic_gen #(.APP_DW(APP_DW), .APP_BW(APP_BW), .AW(AW), .LW(LW)) dut (
        .sdram_clk     (sdram_clk),
        .reset_n       (reset_n),
        .sdr_init_done (sdr_init_done),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_wr_n      (cmd_wr_n),
        .cmd_addr      (cmd_addr),
        .cmd_len       (cmd_len),
        .cmd_seed      (cmd_seed),
        .app           (app_if),
        .busy          (busy),
        .done          (done),
        .err_cnt       (err_cnt),
        .proto_err     (proto_err)
    );

    always #5 sdram_clk = ~sdram_clk;

    int checks   = 0;
    int failures = 0;
    int done_seen = 0;
    logic prev_done = 1'b0;
    logic model_proto = 1'b0;
    logic [APP_DW-1:0] wr_exp[$];
    logic [16:0]       done_exp[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge sdram_clk);
        #1;
    endtask

    // Scoreboard monitor: write words and completion results
    always @(negedge sdram_clk) begin
        logic [16:0] e;
        if (reset_n) begin
            if (app_if.app_wr_next_req) begin
                if (wr_exp.size() == 0) chk("wr_unexpected", app_if.app_wr_next_req, 0);
                else chk("wr_data", app_if.app_wr_data, wr_exp.pop_front());
            end
            if (done) begin
                done_seen++;
                chk("done_single_cycle", prev_done, 0);
                if (done_exp.size() == 0) chk("done_unexpected", done, 0);
                else begin
                    e = done_exp.pop_front();
                    chk("done_err_cnt", err_cnt, e[15:0]);
                    chk("done_proto_err", proto_err, e[16]);
                end
            end
        end
        prev_done = done;
    end

    task automatic clear_app_inputs();
        app_if.app_req_ack     = 1'b0;
        app_if.app_wr_next_req = 1'b0;
        app_if.app_rd_valid    = 1'b0;
        app_if.app_rd_data     = '0;
        app_if.app_last_rd     = 1'b0;
    endtask

    task automatic flush_model();
        wr_exp.delete();
        done_exp.delete();
        model_proto = 1'b0;
    endtask

    task automatic check_req_fields(input logic wr_n, input logic [AW-1:0] addr, input logic [LW-1:0] len);
        chk("req_high", app_if.app_req, 1);
        chk("req_addr", app_if.app_req_addr, addr);
        chk("req_len", app_if.app_req_len, len);
        chk("req_wr_n", app_if.app_req_wr_n, wr_n);
        chk("req_wrap", app_if.app_req_wrap, 0);
        chk("wr_en_n", app_if.app_wr_en_n, 0);
    endtask

    // One command: model expectations pushed, then the controller is emulated.
    task automatic run_cmd(input logic wr_n, input logic [AW-1:0] addr, input int len,
                           input logic [APP_DW-1:0] seed, input int ack_dly,
                           input logic [31:0] corrupt, input int last_at_in, input int abort_at);
        int last_at;
        int beats;
        int errs;
        int to;
        int start_done;
        logic [APP_DW-1:0] word;
        last_at = (last_at_in < 0) ? len - 1 : last_at_in;
        beats   = (len == 0) ? 0 : ((last_at < len - 1) ? last_at + 1 : len);
        errs    = 0;
        if (!wr_n) begin
            for (int k = 0; k < len; k++) wr_exp.push_back(seed + APP_DW'(k));
        end else begin
            for (int k = 0; k < beats; k++) if (k < 32 && corrupt[k]) errs++;
            if (len > 0 && last_at < len - 1) model_proto = 1'b1;
        end
        done_exp.push_back({model_proto, 16'(errs)});
        start_done = done_seen;

        cmd_valid = 1'b1;
        cmd_wr_n  = wr_n;
        cmd_addr  = addr;
        cmd_len   = LW'(len);
        cmd_seed  = seed;
        to = 0;
        while (!cmd_ready && to < 100) begin
            tick();
            to++;
        end
        if (to >= 100) chk("cmd_accept_timeout", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        cmd_wr_n  = $urandom_range(0, 1);
        cmd_addr  = AW'($urandom);
        cmd_len   = LW'($urandom);
        cmd_seed  = $urandom;

        if (len == 0) begin
            chk("null_done_next_cycle", done, 1);
            for (int i = 0; i < 3; i++) begin
                chk("null_no_req", app_if.app_req, 0);
                tick();
            end
        end else begin
            chk("busy_after_accept", busy, 1);
            chk("ready_low_when_busy", cmd_ready, 0);
            chk("first_wr_data", app_if.app_wr_data, seed);
            for (int d = 0; d < ack_dly; d++) begin
                check_req_fields(wr_n, addr, LW'(len));
                tick();
            end
            check_req_fields(wr_n, addr, LW'(len));
            app_if.app_req_ack = 1'b1;
            tick();
            app_if.app_req_ack = 1'b0;
            chk("req_dropped_after_ack", app_if.app_req, 0);
            for (int k = 0; k < beats; k++) begin
                repeat ($urandom_range(0, 2)) tick();
                if (k == abort_at) begin
                    reset_n = 1'b0;
                    flush_model();
                    #1;
                    chk("abort_req_low", app_if.app_req, 0);
                    chk("abort_busy_low", busy, 0);
                    tick();
                    reset_n = 1'b1;
                    for (int i = 0; i < 5; i++) begin
                        tick();
                        chk("abort_no_done", done, 0);
                    end
                    chk("abort_done_count", done_seen - start_done, 0);
                    return;
                end
                if (!wr_n) begin
                    app_if.app_wr_next_req = 1'b1;
                end else begin
                    word = seed + APP_DW'(k);
                    if (k < 32 && corrupt[k]) word = word ^ 32'h0000_0100;
                    app_if.app_rd_valid = 1'b1;
                    app_if.app_rd_data  = word;
                    app_if.app_last_rd  = (k == last_at);
                end
                tick();
                clear_app_inputs();
            end
        end
        to = 0;
        while (busy && to < 10) begin
            tick();
            to++;
        end
        chk("busy_low_after_done", busy, 0);
        chk("done_pulse_count", done_seen - start_done, 1);
        chk("no_req_in_idle", app_if.app_req, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic wr_n;
        int len;
        int last_at;
        clear_app_inputs();
        // Reset with controller not initialised and a command pending
        cmd_valid = 1'b1;
        cmd_len   = LW'(4);
        reset_n   = 1'b0;
        repeat (3) tick();
        chk("rst_app_req", app_if.app_req, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_proto_err", proto_err, 0);
        chk("rst_wr_data", app_if.app_wr_data, 0);
        chk("rst_req_addr", app_if.app_req_addr, 0);
        chk("rst_req_len", app_if.app_req_len, 0);
        chk("rst_wr_en_n", app_if.app_wr_en_n, 0);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("noinit_cmd_ready", cmd_ready, 0);
            chk("noinit_app_req", app_if.app_req, 0);
            chk("noinit_busy", busy, 0);
        end
        cmd_valid = 1'b0;
        sdr_init_done = 1'b1;
        tick();

        run_cmd(1'b0, 26'h000100, 4, 32'hA5A50000, 3, 32'h0, -1, -1);
        run_cmd(1'b1, 26'h000100, 4, 32'hA5A50000, 1, 32'h0, -1, -1);
        run_cmd(1'b1, 26'h000100, 4, 32'hA5A50000, 0, 32'h4, -1, -1);
        run_cmd(1'b0, 26'h000200, 0, 32'h12345678, 0, 32'h0, -1, -1);
        run_cmd(1'b1, 26'h000300, 0, 32'h12345678, 0, 32'h0, -1, -1);
        run_cmd(1'b1, 26'h000400, 4, 32'h00C0FFEE, 2, 32'h0, 1, -1);
        run_cmd(1'b1, 26'h000500, 2, 32'h00000010, 0, 32'h3, -1, -1);
        run_cmd(1'b0, 26'h000600, 256, 32'hFFFFFFFE, 1, 32'h0, -1, -1);
        run_cmd(1'b0, 26'h000700, 256, 32'hFFFFFFFE, 0, 32'h0, -1, 100);

        for (int n = 0; n < 12; n++) begin
            wr_n    = $urandom_range(0, 1);
            len     = $urandom_range(1, 20);
            last_at = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len - 1) : -1;
            run_cmd(wr_n, AW'($urandom), len, $urandom, $urandom_range(0, 3),
                    wr_n ? $urandom : 32'h0, wr_n ? last_at : -1, -1);
        end

        chk("scoreboard_wr_drained", wr_exp.size(), 0);
        chk("scoreboard_done_drained", done_exp.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
